// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file.
// Contents: default widths, DRMUX/SR1MUX select encodings, FSM state type.
package regfile_sb_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 8;

    // Destination select
    localparam logic [1:0] DR_IR119 = 2'b00;
    localparam logic [1:0] DR_NM2   = 2'b01;
    localparam logic [1:0] DR_NM1   = 2'b10;
    localparam logic [1:0] DR_NONE  = 2'b11;

    // Source-1 select
    localparam logic [1:0] SR1_IR119 = 2'b00;
    localparam logic [1:0] SR1_IR86  = 2'b01;
    localparam logic [1:0] SR1_NM2   = 2'b10;
    localparam logic [1:0] SR1_R0    = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Issue / writeback / operand bundle of the scoreboarded register file.
// master: instruction source (drives issue, writeback, clear).
// slave : register file (drives ready, operands, scoreboard, sweep flag).
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic [15:0]         IRout;
    logic [1:0]          DRMUX;
    logic [1:0]          SR1MUX;
    logic                SR2MUX;
    logic                Issue_Valid;
    logic                Issue_Ready;
    logic                WB_Valid;
    logic [IDX_W-1:0]    WB_Idx;
    logic [DATA_W-1:0]   WB_Data;
    logic                Clear;
    logic                Op_Valid;
    logic [DATA_W-1:0]   SR1Out;
    logic [DATA_W-1:0]   SR2Out;
    logic [NUM_REGS-1:0] Busy;
    logic                Clearing;

    modport master (
        output IRout, DRMUX, SR1MUX, SR2MUX, Issue_Valid,
               WB_Valid, WB_Idx, WB_Data, Clear,
        input  Issue_Ready, Op_Valid, SR1Out, SR2Out, Busy, Clearing
    );

    modport slave (
        input  IRout, DRMUX, SR1MUX, SR2MUX, Issue_Valid,
               WB_Valid, WB_Idx, WB_Data, Clear,
        output Issue_Ready, Op_Valid, SR1Out, SR2Out, Busy, Clearing
    );

endinterface

// File: rtl/regfile_sb_hazard_chk.sv
// Combinational index decode and scoreboard hazard check.
// Inputs : instruction register fields, mux selects, Busy vector, writeback port.
// Outputs: sr1/sr2/dr indices, dr_en (instruction has a destination), hazard.
module hazard_chk
    import regfile_sb_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [2:0]          ir_f119,
    input  logic [2:0]          ir_f86,
    input  logic [2:0]          ir_f20,
    input  logic [1:0]          drmux,
    input  logic [1:0]          sr1mux,
    input  logic                sr2mux,
    input  logic [NUM_REGS-1:0] busy,
    input  logic                wb_valid,
    input  logic [IDX_W-1:0]    wb_idx,
    output logic [IDX_W-1:0]    sr1_idx,
    output logic [IDX_W-1:0]    sr2_idx,
    output logic [IDX_W-1:0]    dr_idx,
    output logic                dr_en,
    output logic                hazard
);
    logic [NUM_REGS-1:0] busy_eff;

    always_comb begin
        dr_idx = IDX_W'(ir_f119);
        dr_en  = 1'b1;
        case (drmux)
            DR_IR119: dr_idx = IDX_W'(ir_f119);
            DR_NM2:   dr_idx = IDX_W'(NUM_REGS - 2);
            DR_NM1:   dr_idx = IDX_W'(NUM_REGS - 1);
            default:  dr_en  = 1'b0;
        endcase

        case (sr1mux)
            SR1_IR119: sr1_idx = IDX_W'(ir_f119);
            SR1_IR86:  sr1_idx = IDX_W'(ir_f86);
            SR1_NM2:   sr1_idx = IDX_W'(NUM_REGS - 2);
            default:   sr1_idx = '0;
        endcase

        sr2_idx = IDX_W'(ir_f20);

        // A register being written back this cycle is already free.
        busy_eff = busy & ~(wb_valid ? (NUM_REGS'(1) << wb_idx) : '0);

        hazard = busy_eff[sr1_idx]
               | (~sr2mux & busy_eff[sr2_idx])
               | (dr_en & busy_eff[dr_idx]);
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard, forwarding operand
// capture and a one-register-per-cycle clear sweep.
// Ports: Clk, Reset_n (async, active-low), bus (regfile_sb_if.slave).
//
// state    | meaning
// ST_IDLE  | accepts issues and writebacks; Clear starts a sweep
// ST_CLEAR | zeroes R[cnt] each cycle, issues stalled, writebacks dropped
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic         Clk,
    input  logic         Reset_n,
    regfile_sb_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REGS);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [DATA_W-1:0]   sr1_q, sr1_d, sr2_q, sr2_d;
    logic                op_valid_q, op_valid_d;

    logic [IDX_W-1:0]    sr1_idx, sr2_idx, dr_idx;
    logic                dr_en, hazard, issue_ok;
    logic [DATA_W-1:0]   sr1_val, sr2_val, imm_val;
    logic                unused_ir;

    assign unused_ir = ^{bus.IRout[15:12], bus.IRout[5]};

    hazard_chk #(.NUM_REGS(NUM_REGS)) u_hazard (
        .ir_f119  (bus.IRout[11:9]),
        .ir_f86   (bus.IRout[8:6]),
        .ir_f20   (bus.IRout[2:0]),
        .drmux    (bus.DRMUX),
        .sr1mux   (bus.SR1MUX),
        .sr2mux   (bus.SR2MUX),
        .busy     (busy_q),
        .wb_valid (bus.WB_Valid),
        .wb_idx   (bus.WB_Idx),
        .sr1_idx  (sr1_idx),
        .sr2_idx  (sr2_idx),
        .dr_idx   (dr_idx),
        .dr_en    (dr_en),
        .hazard   (hazard)
    );

    assign issue_ok = bus.Issue_Valid && (state_q == ST_IDLE) && !hazard;
    assign imm_val  = {{(DATA_W-5){bus.IRout[4]}}, bus.IRout[4:0]};

    // Operands see a same-cycle writeback.
    assign sr1_val = (bus.WB_Valid && bus.WB_Idx == sr1_idx) ? bus.WB_Data : regs_q[sr1_idx];
    assign sr2_val = bus.SR2MUX ? imm_val :
                     (bus.WB_Valid && bus.WB_Idx == sr2_idx) ? bus.WB_Data : regs_q[sr2_idx];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        regs_d     = regs_q;
        sr1_d      = sr1_q;
        sr2_d      = sr2_q;
        op_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.WB_Valid) begin
                    regs_d[bus.WB_Idx] = bus.WB_Data;
                    busy_d[bus.WB_Idx] = 1'b0;
                end
                if (issue_ok) begin
                    sr1_d      = sr1_val;
                    sr2_d      = sr2_val;
                    op_valid_d = 1'b1;
                    // Issue wins over a same-cycle writeback to its DR.
                    if (dr_en) busy_d[dr_idx] = 1'b1;
                end
                if (bus.Clear) begin
                    state_d = ST_CLEAR;
                    busy_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(NUM_REGS - 1)) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= '0;
            regs_q     <= '{default: '0};
            sr1_q      <= '0;
            sr2_q      <= '0;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            regs_q     <= regs_d;
            sr1_q      <= sr1_d;
            sr2_q      <= sr2_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign bus.Issue_Ready = issue_ok;
    assign bus.Op_Valid    = op_valid_q;
    assign bus.SR1Out      = sr1_q;
    assign bus.SR2Out      = sr2_q;
    assign bus.Busy        = busy_q;
    assign bus.Clearing    = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: reference model plus operand scoreboard queue.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(16), .NUM_REGS(8))  bus();
    regfile_sb_if #(.DATA_W(32), .NUM_REGS(16)) bus2();

    regfile_sb #(.DATA_W(16), .NUM_REGS(8))  u_dut  (.Clk(clk), .Reset_n(rst_n), .bus(bus));
    regfile_sb #(.DATA_W(32), .NUM_REGS(16)) u_dut2 (.Clk(clk), .Reset_n(rst_n), .bus(bus2));

    int total = 0;
    int bad   = 0;

    logic [15:0] m_regs [8];
    logic [7:0]  m_busy;
    bit          m_clr;
    int          m_cnt;
    bit          m_opv;
    logic [31:0] sbq [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk_ir(input int f119, input int f86, input int low5);
        logic [2:0] a, b;
        logic [4:0] c;
        a = f119[2:0];
        b = f86[2:0];
        c = low5[4:0];
        return {4'b0, a, b, 1'b0, c};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_busy = '0;
        m_clr  = 1'b0;
        m_cnt  = 0;
        m_opv  = 1'b0;
        sbq.delete();
    endtask

    // One clock: drive, check last edge's outputs, predict, advance model.
    task automatic step(input bit iv, input logic [15:0] ir, input logic [1:0] drm,
                        input logic [1:0] s1m, input logic s2m,
                        input bit wbv, input int wbi, input logic [15:0] wbd, input bit clr);
        int dr, s1, s2;
        bit dr_en, rdy, wb_live;
        logic [7:0] eff;
        logic [15:0] v1, v2;
        logic [31:0] e;

        bus.Issue_Valid = iv;   bus.IRout  = ir;     bus.DRMUX = drm;
        bus.SR1MUX      = s1m;  bus.SR2MUX = s2m;    bus.WB_Valid = wbv;
        bus.WB_Idx      = wbi[2:0]; bus.WB_Data = wbd; bus.Clear = clr;
        @(negedge clk);

        chk("op_valid", bus.Op_Valid, m_opv);
        if (m_opv) begin
            e = sbq.pop_front();
            chk("sr1out", bus.SR1Out, e[31:16]);
            chk("sr2out", bus.SR2Out, e[15:0]);
        end
        chk("busy", bus.Busy, m_busy);
        chk("clearing", bus.Clearing, m_clr);

        dr_en = 1'b1;
        dr = 0;
        case (drm)
            2'd0: dr = int'(ir[11:9]);
            2'd1: dr = 6;
            2'd2: dr = 7;
            default: dr_en = 1'b0;
        endcase
        case (s1m)
            2'd0: s1 = int'(ir[11:9]);
            2'd1: s1 = int'(ir[8:6]);
            2'd2: s1 = 6;
            default: s1 = 0;
        endcase
        s2 = int'(ir[2:0]);

        wb_live = wbv && !m_clr;
        eff = m_busy;
        if (wb_live) eff[wbi] = 1'b0;
        rdy = iv && !m_clr && !eff[s1] && !(!s2m && eff[s2]) && !(dr_en && eff[dr]);
        chk("issue_ready", bus.Issue_Ready, rdy);

        if (rdy) begin
            v1 = (wb_live && wbi == s1) ? wbd : m_regs[s1];
            if (s2m) v2 = {{11{ir[4]}}, ir[4:0]};
            else     v2 = (wb_live && wbi == s2) ? wbd : m_regs[s2];
            sbq.push_back({v1, v2});
        end
        m_opv = rdy;

        if (!m_clr) begin
            if (wbv) begin
                m_regs[wbi] = wbd;
                m_busy[wbi] = 1'b0;
            end
            if (rdy && dr_en) m_busy[dr] = 1'b1;
            if (clr) begin
                m_clr  = 1'b1;
                m_busy = '0;
                m_cnt  = 0;
            end
        end else begin
            m_regs[m_cnt] = '0;
            if (m_cnt == 7) m_clr = 1'b0;
            m_cnt = (m_cnt + 1) % 8;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, '0, DR_NONE, SR1_R0, 1'b0, 0, 0, '0, 0);
    endtask

    initial begin
        bus.Issue_Valid = 0; bus.IRout = '0; bus.DRMUX = DR_NONE; bus.SR1MUX = SR1_R0;
        bus.SR2MUX = 0; bus.WB_Valid = 0; bus.WB_Idx = '0; bus.WB_Data = '0; bus.Clear = 0;
        bus2.Issue_Valid = 0; bus2.IRout = '0; bus2.DRMUX = DR_NONE; bus2.SR1MUX = SR1_R0;
        bus2.SR2MUX = 0; bus2.WB_Valid = 0; bus2.WB_Idx = '0; bus2.WB_Data = '0; bus2.Clear = 0;
        model_reset();

        #3;
        chk("rst_busy", bus.Busy, 0);
        chk("rst_opv", bus.Op_Valid, 0);
        chk("rst_clearing", bus.Clearing, 0);
        chk("rst_sr1", bus.SR1Out, 0);
        #14 rst_n = 1'b1;   // t=17, first rising edge after release at 25

        // Write R3, then read it through IR[8:6]; first edge issue also exercised.
        step(0, '0, DR_NONE, SR1_R0, 0, 1, 3, 16'h1234, 0);
        step(1, mk_ir(0, 3, 3), DR_NONE, SR1_IR86, 0, 0, 0, '0, 0);
        idle();

        // RAW hazard on R2 resolved by a forwarded writeback.
        step(1, mk_ir(2, 0, 16), DR_IR119, SR1_R0, 1, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++)
            step(1, mk_ir(0, 2, 1), DR_NONE, SR1_IR86, 1, 0, 0, '0, 0);
        step(1, mk_ir(0, 2, 1), DR_NONE, SR1_IR86, 1, 1, 2, 16'h00FF, 0);
        idle();

        // Immediate: R0 busy must not block when SR2MUX=1 even though IR[2:0]=0.
        step(1, mk_ir(0, 0, 0), DR_IR119, SR1_R0, 1, 0, 0, '0, 0);
        step(1, mk_ir(0, 1, 5'b10000), DR_NONE, SR1_IR86, 1, 0, 0, '0, 0);
        step(1, mk_ir(0, 1, 0), DR_NONE, SR1_IR86, 0, 0, 0, '0, 0);
        step(1, mk_ir(0, 1, 0), DR_NONE, SR1_IR86, 0, 1, 0, 16'h0BAD, 0);
        idle();

        // Same-cycle WB R5 and issue reserving R5.
        step(1, mk_ir(5, 0, 1), DR_IR119, SR1_R0, 1, 1, 5, 16'hABCD, 0);
        idle();

        // Fill every register, read back, then sweep.
        for (int i = 0; i < 8; i++)
            step(0, '0, DR_NONE, SR1_R0, 0, 1, i, 16'h1111 * (i + 1), 0);
        for (int i = 0; i < 8; i += 2)
            step(1, mk_ir(0, i, i + 1), DR_NONE, SR1_IR86, 0, 0, 0, '0, 0);
        step(1, mk_ir(1, 0, 0), DR_IR119, SR1_R0, 1, 0, 0, '0, 1);
        for (int i = 0; i < 8; i++)
            step(1, mk_ir(0, 2, 3), DR_NONE, SR1_IR86, 0, 1, i, 16'hFFFF, (i == 3));
        idle();
        for (int i = 0; i < 8; i += 2)
            step(1, mk_ir(0, i, i + 1), DR_NONE, SR1_IR86, 0, 0, 0, '0, 0);
        idle();

        // Asynchronous reset in the middle of a sweep.
        step(0, '0, DR_NONE, SR1_R0, 0, 1, 4, 16'h5A5A, 0);
        step(1, mk_ir(0, 4, 4), DR_NM1, SR1_IR86, 0, 0, 0, '0, 0);
        step(0, '0, DR_NONE, SR1_R0, 0, 0, 0, '0, 1);
        idle();
        idle();
        rst_n = 1'b0;
        #2;
        chk("mid_rst_sr1", bus.SR1Out, 0);
        chk("mid_rst_sr2", bus.SR2Out, 0);
        chk("mid_rst_busy", bus.Busy, 0);
        chk("mid_rst_opv", bus.Op_Valid, 0);
        chk("mid_rst_clearing", bus.Clearing, 0);
        model_reset();
        #1 rst_n = 1'b1;
        step(1, mk_ir(0, 4, 4), DR_NONE, SR1_IR86, 0, 0, 0, '0, 0);
        idle();
        chk("sb_empty", sbq.size(), 0);

        // Wide configuration: 16 x 32-bit.
        bus2.WB_Valid = 1; bus2.WB_Idx = 4'd3; bus2.WB_Data = 32'h1234_5678;
        @(posedge clk); #1;
        bus2.WB_Valid = 0; bus2.Issue_Valid = 1; bus2.IRout = mk_ir(0, 3, 5'b10000);
        bus2.DRMUX = DR_NM1; bus2.SR1MUX = SR1_IR86; bus2.SR2MUX = 1;
        @(negedge clk);
        chk("w_ready", bus2.Issue_Ready, 1);
        @(posedge clk); #1;
        bus2.Issue_Valid = 0;
        @(negedge clk);
        chk("w_opv", bus2.Op_Valid, 1);
        chk("w_sr1", bus2.SR1Out, 32'h1234_5678);
        chk("w_sr2", bus2.SR2Out, 32'hFFFF_FFF0);
        chk("w_busy", bus2.Busy, 16'h8000);
        @(negedge clk);
        chk("w_opv_drop", bus2.Op_Valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 DATA_W, 16, register and data width in bits.
REQ-002 NUM_REGS, 8, register count; power of two, at least 8; IDX_W = log2(NUM_REGS).
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 IRout  input  16  current instruction word; 3-bit fields zero-extended to IDX_W.
REQ-006 DRMUX  input  2  destination select: 00 IR[11:9], 01 NUM_REGS-2, 10 NUM_REGS-1, 11 no destination.
REQ-007 SR1MUX  input  2  source-1 select: 00 IR[11:9], 01 IR[8:6], 10 NUM_REGS-2, 11 index 0.
REQ-008 SR2MUX  input  1  0 = register IR[2:0]; 1 = immediate, sign-extended IR[4:0].
REQ-009 Issue_Valid  input  1  an instruction requests operand read and DR reservation.
REQ-010 Issue_Ready  output  1  issue accepted this cycle.
REQ-011 WB_Valid, WB_Idx, WB_Data  input  1, IDX_W, DATA_W  writeback port.
REQ-012 Clear  input  1  one-cycle pulse that starts a register sweep.
REQ-013 Op_Valid  output  1  operands valid, asserted one cycle after an accepted issue.
REQ-014 SR1Out, SR2Out  output  DATA_W  registered operands.
REQ-015 Busy  output  NUM_REGS  scoreboard, one bit per register.
REQ-016 Clearing  output  1  high while the sweep runs.

Function
REQ-017 Issue_Ready = Issue_Valid, FSM in IDLE, and no pending hazard; a hazard is SR1 busy, SR2 busy (only when SR2MUX=0), or DR busy (only when DRMUX!=11).
- A busy bit being cleared by WB this same cycle does not count as busy.
REQ-018 On an accepted issue, SR1Out/SR2Out capture the operands and Op_Valid pulses high on the next cycle.
- Capture is forwarded: a source equal to WB_Idx with WB_Valid set captures WB_Data.
- Op_Valid is otherwise 0; SR1Out/SR2Out hold their values.
REQ-019 On an accepted issue with DRMUX!=11, Busy[DR] is set at the edge.
REQ-020 On WB_Valid in IDLE, R[WB_Idx] is written with WB_Data and Busy[WB_Idx] is cleared.
- If the same cycle also issues with DR = WB_Idx, the busy bit ends set (issue wins) and the data is still written.
REQ-021 WB_Valid to a non-busy register still writes; there is no error flag.
REQ-022 FSM states: IDLE, CLEAR. IDLE moves to CLEAR on Clear; CLEAR moves to IDLE after the register at index NUM_REGS-1 is zeroed.
REQ-023 On entering CLEAR, all Busy bits are zeroed.
- CLEAR zeroes one register per cycle, index 0 upward, using an IDX_W counter that wraps to 0 on exit.
- The sweep lasts exactly NUM_REGS cycles.
REQ-024 In CLEAR: Issue_Ready=0, Clearing=1, WB_Valid is ignored, and a further Clear is ignored.
REQ-025 Clear and Issue_Valid in the same IDLE cycle: the issue is accepted, and the sweep begins on the next cycle.
REQ-026 Immediate arithmetic: SR2Out = {(DATA_W-5) copies of IR[4], IR[4:0]}.

Reset
REQ-027 Reset_n low asynchronously sets all registers, SR1Out, SR2Out, Busy, Op_Valid, Clearing and the sweep counter to 0, and the FSM to IDLE, including mid-sweep and mid-issue.
REQ-028 After Reset_n is released, the first accepted issue is possible on the first rising edge.

Structure
REQ-029 A shared package holds the DRMUX and SR1MUX encoding constants, the FSM state enum, and the default DATA_W and NUM_REGS.
REQ-030 Sub-module hazard_chk (combinational, parametrised by NUM_REGS) computes SR1, SR2 and DR indices and the hazard flag; the storage, scoreboard and FSM stay in regfile_sb.

Verification
REQ-031 WB R3=0x1234; then issue SR1MUX=01 with IR[8:6]=3 -> next cycle Op_Valid=1, SR1Out=0x1234.
REQ-032 Issue with DR=R2 (DRMUX=00), then issue sourcing R2 -> second issue has Issue_Ready=0 until WB R2=0x00FF.
- On the WB cycle the issue is accepted and SR1Out=0x00FF (forwarded).
REQ-033 SR2MUX=1, IR[4:0]=10000 -> SR2Out=0xFFF0; Busy unaffected by IR[2:0].
REQ-034 Write R0..R7 nonzero, pulse Clear -> Clearing=1 for exactly 8 cycles.
- During the sweep, WB_Valid is ignored and issues stall.
- Afterwards all registers read 0 and Busy=0.
REQ-035 Same cycle: WB R5 and issue DR=R5 -> R5 is written and Busy[5]=1 afterwards.
REQ-036 Pull Reset_n low mid-sweep -> all outputs 0 immediately; FSM IDLE after release.
- Repeat REQ-031 with NUM_REGS=16 and DATA_W=32.
